// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: decode/writeback/dmem/redirect inputs and stall/flush/PC outputs.
// HAZARD_PERF_EN adds the perf_stall_cnt/perf_flush_cnt outputs.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned BIN_DIG = 32
);
  logic               dec_valid;
  logic [4:0]         dec_rs1;
  logic [4:0]         dec_rs2;
  logic               dec_use_rs1;
  logic               dec_use_rs2;
  logic [4:0]         dec_rd;
  logic               dec_we;
  logic               wb_valid;
  logic [4:0]         wb_rd;
  logic               dmem_busy;
  logic               redirect_req;
  logic [BIN_DIG-1:0] redirect_pc;

  logic               stall_fetch;
  logic               stall_decode;
  logic               issue;
  logic               flush_fetch;
  logic               flush_decode;
  logic               pc_load;
  logic [BIN_DIG-1:0] pc_target;
  logic [31:0]        busy_map;

`ifdef HAZARD_PERF_EN
  logic [31:0]        perf_stall_cnt;
  logic [31:0]        perf_flush_cnt;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_we,
           wb_valid, wb_rd, dmem_busy, redirect_req, redirect_pc,
    input  stall_fetch, stall_decode, issue, flush_fetch, flush_decode, pc_load,
           pc_target, busy_map, perf_stall_cnt, perf_flush_cnt
  );
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_we,
           wb_valid, wb_rd, dmem_busy, redirect_req, redirect_pc,
    output stall_fetch, stall_decode, issue, flush_fetch, flush_decode, pc_load,
           pc_target, busy_map, perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_we,
           wb_valid, wb_rd, dmem_busy, redirect_req, redirect_pc,
    input  stall_fetch, stall_decode, issue, flush_fetch, flush_decode, pc_load,
           pc_target, busy_map
  );
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_we,
           wb_valid, wb_rd, dmem_busy, redirect_req, redirect_pc,
    output stall_fetch, stall_decode, issue, flush_fetch, flush_decode, pc_load,
           pc_target, busy_map
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: register scoreboard for RAW/WAW-capacity stalls plus redirect/flush sequencer.
// Optional macro HAZARD_PERF_EN adds saturating stall-cycle and redirect counters.
module pipe_hazard_ctrl #(
  parameter int unsigned BIN_DIG      = 32,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic               CLK,
  input logic               RST,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned NREG = 32;
  localparam int unsigned FC_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [FC_W-1:0]  FLUSH_LD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH} state_t;

  state_t             r_state, w_state_nxt;
  logic [FC_W-1:0]    r_fcnt, w_fcnt_nxt;
  logic [BIN_DIG-1:0] r_pc_target, w_pc_target_nxt;
  logic [CNT_W-1:0]   r_cnt [NREG];
  logic [CNT_W-1:0]   w_cnt_nxt [NREG];
  logic [NREG-1:0]    r_busy_map, w_busy_nxt;
  logic w_raw, w_waw_full, w_stall, w_flush_active, w_issue;
  logic w_pc_load, w_flush;

  // Hazard detection straight off the registered counts: no writeback bypass.
  assign w_raw = bus.dec_valid &
                 ((bus.dec_use_rs1 & (r_cnt[bus.dec_rs1] != '0)) |
                  (bus.dec_use_rs2 & (r_cnt[bus.dec_rs2] != '0)));
  assign w_waw_full = bus.dec_valid & bus.dec_we & (bus.dec_rd != 5'd0) &
                      (r_cnt[bus.dec_rd] == CNT_MAX);
  assign w_stall        = w_raw | w_waw_full | bus.dmem_busy;
  assign w_flush_active = (r_state != ST_IDLE);
  assign w_issue = ~RST & bus.dec_valid & ~w_stall & ~bus.redirect_req & ~w_flush_active;

  assign bus.stall_fetch  = ~RST & w_stall & ~w_flush_active;
  assign bus.stall_decode = ~RST & w_stall & ~w_flush_active;
  assign bus.issue        = w_issue;
  assign bus.flush_fetch  = w_flush;
  assign bus.flush_decode = w_flush;
  assign bus.pc_load      = w_pc_load;
  assign bus.pc_target    = r_pc_target;
  assign bus.busy_map     = r_busy_map;

  // Per-register count update; a writeback to an idle register is dropped.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      logic inc_hit, dec_hit;
      inc_hit = w_issue & bus.dec_we & (bus.dec_rd == 5'(i));
      dec_hit = bus.wb_valid & (bus.wb_rd == 5'(i)) & (r_cnt[i] != '0);
      w_cnt_nxt[i] = r_cnt[i];
      if (i == 0) begin
        w_cnt_nxt[i] = '0;
      end else if (inc_hit && !dec_hit) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end else if (dec_hit && !inc_hit) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
      end
      w_busy_nxt[i] = (w_cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_busy_map <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_busy_map <= w_busy_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_fcnt      <= '0;
      r_pc_target <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_pc_target <= w_pc_target_nxt;
    end
  end

  // Redirect sequencer: one LOAD cycle, then FLUSH until the counter expires.
  always_comb begin
    w_state_nxt     = r_state;
    w_fcnt_nxt      = r_fcnt;
    w_pc_target_nxt = r_pc_target;
    w_pc_load       = 1'b0;
    w_flush         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.redirect_req) begin
          w_state_nxt     = ST_LOAD;
          w_pc_target_nxt = bus.redirect_pc;
        end
      end
      ST_LOAD: begin
        w_pc_load   = 1'b1;
        w_flush     = 1'b1;
        w_fcnt_nxt  = FLUSH_LD;
        w_state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        w_flush    = 1'b1;
        w_fcnt_nxt = r_fcnt - FC_W'(1);
        if (r_fcnt <= FC_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall, r_perf_flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (bus.stall_decode && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if ((r_state == ST_IDLE) && bus.redirect_req && (r_perf_flush != '1))
        r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall;
  assign bus.perf_flush_cnt = r_perf_flush;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle comparison against a behavioural model plus literal pins.
module tb_pipe_hazard_ctrl;
  localparam int unsigned BIN_DIG      = 32;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int          CNT_MAX      = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_hazard_ctrl_if #(.BIN_DIG(BIN_DIG)) bus ();

  pipe_hazard_ctrl #(.BIN_DIG(BIN_DIG), .CNT_W(2), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending writes per register and remaining flush cycles.
  int          m_cnt [32];
  int          m_flush_left = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_perf_stall = '0;
  logic [31:0] m_perf_flush = '0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    bit h;
    h = bus.dmem_busy;
    if (bus.dec_valid) begin
      if (bus.dec_use_rs1 && m_cnt[bus.dec_rs1] > 0) h = 1'b1;
      if (bus.dec_use_rs2 && m_cnt[bus.dec_rs2] > 0) h = 1'b1;
      if (bus.dec_we && bus.dec_rd != 5'd0 && m_cnt[bus.dec_rd] == CNT_MAX) h = 1'b1;
    end
    return h;
  endfunction

  function automatic bit m_stall();
    return !rst && m_hazard() && (m_flush_left == 0);
  endfunction

  function automatic bit m_issue();
    return !rst && bus.dec_valid && !m_hazard() && !bus.redirect_req && (m_flush_left == 0);
  endfunction

  always @(posedge clk) begin : model_update
    int old [32];
    bit iss;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_flush_left = 0;
      m_pc         = '0;
      m_perf_stall = '0;
      m_perf_flush = '0;
      chk_en       = 1'b1;
    end else begin
      iss = m_issue();
      if (m_stall() && m_perf_stall != 32'hFFFF_FFFF) m_perf_stall = m_perf_stall + 1;
      old = m_cnt;
      if (iss && bus.dec_we && bus.dec_rd != 5'd0) m_cnt[bus.dec_rd] = m_cnt[bus.dec_rd] + 1;
      if (bus.wb_valid && bus.wb_rd != 5'd0 && old[bus.wb_rd] > 0)
        m_cnt[bus.wb_rd] = m_cnt[bus.wb_rd] - 1;
      if (m_flush_left > 0) begin
        m_flush_left = m_flush_left - 1;
      end else if (bus.redirect_req) begin
        m_flush_left = FLUSH_CYCLES;
        m_pc         = bus.redirect_pc;
        if (m_perf_flush != 32'hFFFF_FFFF) m_perf_flush = m_perf_flush + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] bm;
    if (chk_en) begin
      bm = '0;
      for (int i = 0; i < 32; i++) bm[i] = (m_cnt[i] > 0);
      chk("stall_fetch",  bus.stall_fetch,  m_stall());
      chk("stall_decode", bus.stall_decode, m_stall());
      chk("issue",        bus.issue,        m_issue());
      chk("flush_fetch",  bus.flush_fetch,  m_flush_left > 0);
      chk("flush_decode", bus.flush_decode, m_flush_left > 0);
      chk("pc_load",      bus.pc_load,      m_flush_left == FLUSH_CYCLES);
      chk("pc_target",    bus.pc_target,    m_pc);
      chk("busy_map",     bus.busy_map,     bm);
`ifdef HAZARD_PERF_EN
      chk("perf_stall_cnt", bus.perf_stall_cnt, m_perf_stall);
      chk("perf_flush_cnt", bus.perf_flush_cnt, m_perf_flush);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.dec_valid    = 1'b0;
    bus.dec_rs1      = 5'd0;
    bus.dec_rs2      = 5'd0;
    bus.dec_use_rs1  = 1'b0;
    bus.dec_use_rs2  = 1'b0;
    bus.dec_rd       = 5'd0;
    bus.dec_we       = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.dmem_busy    = 1'b0;
    bus.redirect_req = 1'b0;
    bus.redirect_pc  = '0;
  endtask

  initial begin
    // Reset held for two edges with every input high.
    rst              = 1'b1;
    bus.dec_valid    = 1'b1;
    bus.dec_rs1      = 5'h1f;
    bus.dec_rs2      = 5'h1f;
    bus.dec_use_rs1  = 1'b1;
    bus.dec_use_rs2  = 1'b1;
    bus.dec_rd       = 5'h1f;
    bus.dec_we       = 1'b1;
    bus.wb_valid     = 1'b1;
    bus.wb_rd        = 5'h1f;
    bus.dmem_busy    = 1'b1;
    bus.redirect_req = 1'b1;
    bus.redirect_pc  = '1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall_lit", bus.stall_fetch, 1'b0);
    chk("rst_issue_lit", bus.issue, 1'b0);
    chk("rst_pcload_lit", bus.pc_load, 1'b0);
    tick();
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    chk("post_rst_busy_lit", bus.busy_map, 32'h0);
    chk("post_rst_flush_lit", bus.flush_fetch, 1'b0);
    chk("post_rst_pct_lit", bus.pc_target, 32'h0);
    tick();

    // RAW hazard on x5, cleared the cycle after writeback.
    bus.dec_valid = 1'b1; bus.dec_rd = 5'd5; bus.dec_we = 1'b1;
    @(negedge clk);
    chk("raw_first_issue_lit", bus.issue, 1'b1);
    tick();
    bus.dec_rd = 5'd0; bus.dec_we = 1'b0; bus.dec_rs1 = 5'd5; bus.dec_use_rs1 = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
    @(negedge clk);
    chk("raw_stall_f_lit", bus.stall_fetch, 1'b1);
    chk("raw_stall_d_lit", bus.stall_decode, 1'b1);
    chk("raw_issue_lit", bus.issue, 1'b0);
    chk("raw_busy5_lit", bus.busy_map[5], 1'b1);
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("raw_clear_stall_lit", bus.stall_fetch, 1'b0);
    chk("raw_clear_issue_lit", bus.issue, 1'b1);
    chk("raw_clear_busy5_lit", bus.busy_map[5], 1'b0);
    tick();
    idle_in();

    // x0 is never tracked.
    bus.dec_valid = 1'b1; bus.dec_rd = 5'd0; bus.dec_we = 1'b1;
    @(negedge clk);
    chk("x0_write_issue_lit", bus.issue, 1'b1);
    tick();
    bus.dec_we = 1'b0; bus.dec_rs1 = 5'd0; bus.dec_use_rs1 = 1'b1;
    @(negedge clk);
    chk("x0_read_stall_lit", bus.stall_decode, 1'b0);
    chk("x0_read_busy_lit", bus.busy_map, 32'h0);
    tick();
    idle_in();

    // Counter saturation on x7 and simultaneous issue/writeback.
    bus.dec_valid = 1'b1; bus.dec_rd = 5'd7; bus.dec_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("waw_fill_issue_lit", bus.issue, 1'b1);
      tick();
    end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
    @(negedge clk);
    chk("waw_full_stall_lit", bus.stall_decode, 1'b1);
    chk("waw_full_issue_lit", bus.issue, 1'b0);
    tick();
    @(negedge clk);
    chk("waw_after_wb_issue_lit", bus.issue, 1'b1);
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("waw_same_cycle_issue_lit", bus.issue, 1'b1);
    tick();
    @(negedge clk);
    chk("waw_refull_stall_lit", bus.stall_fetch, 1'b1);
    chk("waw_refull_busy7_lit", bus.busy_map[7], 1'b1);
    tick();
    idle_in();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7;
    tick(); tick(); tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("waw_drained_busy_lit", bus.busy_map, 32'h0);
    tick();

    // Redirect: LOAD then one FLUSH cycle; second request ignored.
    bus.dec_valid = 1'b1; bus.redirect_req = 1'b1; bus.redirect_pc = 32'h0000_0100;
    @(negedge clk);
    chk("redir_req_issue_lit", bus.issue, 1'b0);
    tick();
    bus.redirect_pc = 32'h0000_0200;
    @(negedge clk);
    chk("redir_pcload_lit", bus.pc_load, 1'b1);
    chk("redir_pct_lit", bus.pc_target, 32'h0000_0100);
    chk("redir_ff1_lit", bus.flush_fetch, 1'b1);
    chk("redir_fd1_lit", bus.flush_decode, 1'b1);
    chk("redir_issue1_lit", bus.issue, 1'b0);
    tick();
    bus.redirect_req = 1'b0; bus.dmem_busy = 1'b1;
    @(negedge clk);
    chk("redir_pcload2_lit", bus.pc_load, 1'b0);
    chk("redir_ff2_lit", bus.flush_fetch, 1'b1);
    chk("redir_flush_over_stall_lit", bus.stall_fetch, 1'b0);
    chk("redir_issue2_lit", bus.issue, 1'b0);
    tick();
    bus.dmem_busy = 1'b0;
    @(negedge clk);
    chk("redir_done_ff_lit", bus.flush_fetch, 1'b0);
    chk("redir_done_issue_lit", bus.issue, 1'b1);
    chk("redir_ignored_pct_lit", bus.pc_target, 32'h0000_0100);
    tick();

    // dmem busy for three cycles.
    bus.dmem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dmem_stall_lit", bus.stall_decode, 1'b1);
      chk("dmem_issue_lit", bus.issue, 1'b0);
      tick();
    end
    bus.dmem_busy = 1'b0;
    @(negedge clk);
    chk("dmem_release_issue_lit", bus.issue, 1'b1);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_total_lit", bus.perf_stall_cnt, 32'd6);
    chk("perf_flush_total_lit", bus.perf_flush_cnt, 32'd1);
`endif
    tick();
    idle_in();

    // Reset during LOAD aborts the flush.
    bus.redirect_req = 1'b1; bus.redirect_pc = 32'h0000_0300;
    tick();
    bus.redirect_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_load_ff_lit", bus.flush_fetch, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ff_lit", bus.flush_fetch, 1'b0);
    chk("midrst_pcload_lit", bus.pc_load, 1'b0);
    chk("midrst_pct_lit", bus.pc_target, 32'h0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
